// File: rtl/board_pkg.sv
// Shared board-level constants and types for the key/HEX display path.
package board_pkg;

  localparam int DIGITS_C     = 6;
  localparam int DEBOUNCE_1MS = 50000;
  localparam logic KEY_PRESSED = 1'b0;

  typedef logic [3:0] bcd_digit_t;

endpackage : board_pkg

// File: rtl/key_debounce.sv
// Two-flop synchroniser, debounce counter, stable-level register and
// registered press detector for a single active-low push-button.
module key_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Debounce: count while the synchronised key disagrees with the stable
  // value; any agreeing cycle restarts the window, so bounce never commits.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = (stable_prev_q != KEY_PRESSED) && (stable_q == KEY_PRESSED);
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; everything idles as "released" out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
      cnt_q         <= '0;
      pulse_q       <= 1'b0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      pulse_q       <= pulse_d;
    end
  end

  assign level       = (stable_q == KEY_PRESSED);
  assign press_pulse = pulse_q;

endmodule : key_debounce

// File: rtl/key_bcd_counter.sv
// Debounced push-button event counter feeding the six-digit HEX display:
// KEY[0] increments a packed BCD count, KEY[1] clears it.
module key_bcd_counter
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
  parameter int DIGITS          = DIGITS_C
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          key,
  output logic [4*DIGITS-1:0] bcd,
  output logic                inc_pulse,
  output logic                clr_pulse,
  output logic                wrap,
  output logic [1:0]          key_level
);

  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_inc;
  logic [DIGITS:0]     carry;
  logic                wrap_q, wrap_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (key[0]),
    .level      (key_level[0]),
    .press_pulse(inc_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (key[1]),
    .level      (key_level[1]),
    .press_pulse(clr_pulse)
  );

  // Ripple-carry BCD increment: a digit at 9 rolls to 0 and carries onward.
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_t cur;
      assign cur          = bcd_q[4*gi +: 4];
      assign carry[gi+1]  = carry[gi] & (cur == 4'd9);
      assign bcd_inc[4*gi +: 4] = !carry[gi]     ? cur :
                                  (cur == 4'd9)  ? 4'd0 :
                                                   cur + 4'd1;
    end
  endgenerate

  // Next count: clear beats increment; wrap only when every digit rolled over.
  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (clr_pulse) begin
      bcd_d = '0;
    end else if (inc_pulse) begin
      bcd_d  = bcd_inc;
      wrap_d = carry[DIGITS];
    end
  end

  // Count and wrap strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule : key_bcd_counter

// File: tb/tb_key_bcd_counter.sv
// Directed bench for key_bcd_counter with a short debounce window. A second,
// two-digit instance shares the stimulus so roll-over can be reached quickly.
module tb_key_bcd_counter;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  key;
  logic [23:0] bcd;
  logic        inc_pulse, clr_pulse, wrap;
  logic [1:0]  key_level;
  logic [7:0]  bcd_s;
  logic        inc_s, clr_s, wrap_s;
  logic [1:0]  lvl_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_bcd_counter #(.DEBOUNCE_CYCLES(DB), .DIGITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .bcd(bcd),
    .inc_pulse(inc_pulse), .clr_pulse(clr_pulse), .wrap(wrap), .key_level(key_level)
  );

  key_bcd_counter #(.DEBOUNCE_CYCLES(DB), .DIGITS(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .key(key), .bcd(bcd_s),
    .inc_pulse(inc_s), .clr_pulse(clr_s), .wrap(wrap_s), .key_level(lvl_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key   = 2'b11;
    cycles(3);
    rst_n = 1'b1;
  endtask

  // One full press/release, long enough for both debounce windows to settle.
  task automatic press(input logic [1:0] k);
    key = k;
    cycles(10);
    key = 2'b11;
    cycles(10);
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 2'b11;
    cycles(3);

    // Reset values
    check("rst_bcd",   32'(bcd), 32'h0);
    check("rst_inc",   32'(inc_pulse), 32'h0);
    check("rst_clr",   32'(clr_pulse), 32'h0);
    check("rst_wrap",  32'(wrap), 32'h0);
    check("rst_level", 32'(key_level), 32'h0);
    rst_n = 1'b1;

    // Idle for 100 cycles: nothing moves
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outs", {bcd, inc_pulse, clr_pulse, wrap, key_level}, 32'h0);
    end
    $display("idle: bcd=%h after 100 cycles", bcd);

    // Clean KEY[0] press: pulse only at offset 6, count visible from 7
    key = 2'b10;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("clean_inc",   32'(inc_pulse), 32'(k == 2 + DB));
      check("clean_level", 32'(key_level), (k >= 1 + DB) ? 32'h1 : 32'h0);
      check("clean_bcd",   32'(bcd), (k >= 3 + DB) ? 32'h1 : 32'h0);
    end
    key = 2'b11;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("release_inc", 32'(inc_pulse), 32'h0);
      check("release_bcd", 32'(bcd), 32'h1);
    end
    check("release_level", 32'(key_level), 32'h0);
    $display("clean press: bcd=%h", bcd);

    // Bouncing press: only the final steady low completes a window
    do_reset();
    begin
      logic [5:0] bounce;
      bounce = 6'b100100;   // applied LSB first: low,low,high,low,low,high
      for (int i = 0; i < 6; i++) begin
        key = {1'b1, bounce[i]};
        @(negedge clk);
        check("bounce_inc", 32'(inc_pulse), 32'h0);
      end
    end
    key = 2'b10;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      check("bounce_steady_inc", 32'(inc_pulse), 32'(k == 2 + DB));
    end
    key = 2'b11;
    cycles(10);
    check("bounce_bcd", 32'(bcd), 32'h1);
    $display("bounce press: bcd=%h", bcd);

    // Carry ripple: 12, then 19, then 20
    do_reset();
    repeat (12) press(2'b10);
    check("preload_12", 32'(bcd), 32'h12);
    repeat (7) press(2'b10);
    check("preload_19", 32'(bcd), 32'h19);
    press(2'b10);
    check("carry_20", 32'(bcd), 32'h20);
    $display("carry ripple: bcd=%h", bcd);

    // Roll-over on the two-digit instance (all nines -> 0 with wrap)
    do_reset();
    repeat (99) press(2'b10);
    check("pre_wrap_small", 32'(bcd_s), 32'h99);
    check("pre_wrap_main",  32'(bcd), 32'h99);
    key = 2'b10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("wrap_small_flag", 32'(wrap_s), 32'(k == 3 + DB));
      check("wrap_small_bcd",  32'(bcd_s), (k >= 3 + DB) ? 32'h0 : 32'h99);
      check("wrap_main_flag",  32'(wrap), 32'h0);
    end
    key = 2'b11;
    cycles(10);
    check("wrap_main_bcd", 32'(bcd), 32'h100);
    $display("wrap: small bcd=%h main bcd=%h", bcd_s, bcd);

    // Simultaneous inc and clear at 42: clear wins, no wrap
    do_reset();
    repeat (42) press(2'b10);
    check("pre_both_bcd", 32'(bcd), 32'h42);
    key = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("both_inc",  32'(inc_pulse), 32'(k == 2 + DB));
      check("both_clr",  32'(clr_pulse), 32'(k == 2 + DB));
      check("both_bcd",  32'(bcd), (k >= 3 + DB) ? 32'h0 : 32'h42);
      check("both_wrap", 32'(wrap), 32'h0);
    end
    key = 2'b11;
    cycles(10);
    $display("inc+clr: bcd=%h", bcd);

    // Reset in the middle of a debounce window (cnt == 2) at count 5
    do_reset();
    repeat (5) press(2'b10);
    check("pre_midrst_bcd", 32'(bcd), 32'h5);
    key = 2'b10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_pre_inc", 32'(inc_pulse), 32'h0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bcd",   32'(bcd), 32'h0);
    check("midrst_level", 32'(key_level), 32'h0);
    check("midrst_inc",   32'(inc_pulse), 32'h0);
    rst_n = 1'b1;
    // Key stays low: a fresh window starts from the first post-reset edge (offset 5)
    for (int k = 5; k < 20; k++) begin
      @(negedge clk);
      check("midrst_post_inc",   32'(inc_pulse), 32'(k == 5 + 2 + DB));
      check("midrst_post_bcd",   32'(bcd), (k >= 5 + 3 + DB) ? 32'h1 : 32'h0);
      check("midrst_post_level", 32'(key_level), (k >= 5 + 1 + DB) ? 32'h1 : 32'h0);
    end
    key = 2'b11;
    cycles(10);
    $display("mid-debounce reset: bcd=%h", bcd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_key_bcd_counter

// File: doc/key_bcd_counter.md
Name: key_bcd_counter

Overview:
- Upstream feeder for the board's six-digit HEX display stage.
- Takes the two raw active-low push-buttons (KEY[1:0]), synchronises and debounces them, and maintains a 6-digit BCD event counter.
- KEY[0] press increments the count; KEY[1] press clears it.
- The packed BCD output drives the seven-segment encoder directly, one nibble per HEX digit (digit 0 = HEX0).

Parameters:
- DEBOUNCE_CYCLES, 50000, cycles a synchronised key must differ from its stable value before the change is accepted (1 ms at 50 MHz); legal range 2..2^20.
- DIGITS, 6, number of BCD digits; fixed at 6 for the board, parameterised for sim only.

Ports:
- clk  input  1  system clock, 50 MHz on board.
- rst_n  input  1  synchronous reset, active-low.
- key  input  2  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
- bcd  output  4*DIGITS  packed count; bcd[3:0] = units, bcd[23:20] = hundred-thousands.
- inc_pulse  output  1  one-cycle strobe on an accepted KEY[0] press.
- clr_pulse  output  1  one-cycle strobe on an accepted KEY[1] press.
- wrap  output  1  one-cycle strobe when the count rolls from 999999 to 000000.
- key_level  output  2  debounced, active-high pressed state (1 = held), intended for LEDs.

Behaviour:
- Reset values (rst_n low at a clk edge): bcd = 0, inc_pulse = 0, clr_pulse = 0, wrap = 0, key_level = 2'b00.
- Reset values for internal state: synchroniser flops = 1, stable state = 1 (released), debounce counters = 0.
- Reset is honoured mid-debounce and mid-increment; no partial update survives.
- Synchroniser: two flops per key. The synchronised value lags raw by 2 cycles.
- Debounce, per key, independent:
  - cnt counts up each cycle while sync != stable.
  - cnt returns to 0 on any cycle where sync == stable, so bounce restarts the window.
  - When sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
- Edge detection, registered:
  - Press = stable 1->0. Release = stable 0->1 and produces no event.
  - The pulse is asserted the cycle after stable changes, for exactly 1 cycle.
- Latency: clean raw press first sampled at edge N gives a pulse high during cycle N+2+DEBOUNCE_CYCLES. The bench measures this exact value.
- Holding a key produces exactly one pulse; auto-repeat is not supported.
- key_level = ~stable.
- Counter update, on the cycle after the pulse (bcd registered from the pulse):
  - clr_pulse: bcd <= 0.
  - inc_pulse alone: BCD increment with ripple carry. A digit at 9 becomes 0 and carries; other digits are unchanged.
  - bcd == all-9s with increment: bcd <= 0 and wrap = 1 in the same cycle bcd becomes 0.
  - clr and inc pulses in the same cycle: clear wins, no increment, wrap stays 0.
- Digits never hold values 10..15. Nibbles are always legal BCD.
- No state machine beyond the per-key debounce (states STABLE / COUNTING, implied by cnt != 0).

Decomposition:
- Shared package board_pkg:
  - DIGITS_C = 6.
  - bcd_digit_t = 4-bit type.
  - KEY_PRESSED = 1'b0.
  - DEBOUNCE_1MS = 50000.
- Sub-module key_debounce (params DEBOUNCE_CYCLES):
  - Ports: clk, rst_n, raw, level, press_pulse.
  - Contains the synchroniser, counter, stable register and edge detect.
  - Instantiated twice.
- The BCD increment stays in the top module as a generate loop over DIGITS.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset then idle, keys = 2'b11 for 100 cycles -> bcd = 0, all pulses 0, key_level = 00.
- Clean KEY[0] low held 20 cycles, first sampled at edge N -> inc_pulse high only in cycle N+6; bcd = 000001 from cycle N+7; key_level[0] = 1 while held; release produces no pulse.
- KEY[0] bouncing (low 2, high 1, low 2, high 1) then steady low -> exactly one inc_pulse, first counted from the last steady edge; bcd = 000001.
- Preload 12 presses, then 7 more -> bcd = 0x000019; one further press -> 0x000020 (carry ripple).
- Drive to 999999 via 999999 presses (or a force in sim) then press -> bcd = 0, wrap high for 1 cycle, coinciding with bcd = 0.
- Press KEY[0] and KEY[1] on the same cycle with count 000042 -> both pulses in the same cycle; bcd = 0, wrap = 0.
- Assert rst_n low mid-debounce (cnt = 2) with count 000005 -> bcd = 0 next edge, no pulse after reset while the key remains low until a new full debounce window completes.
